// File: rtl/lpc_autocorr_seq_if.sv
// Sample-in / lag-out handshake bundle for the LPC autocorrelation sequencer.
// master drives samples and accepts lags; slave is the sequencer.
interface lpc_autocorr_seq_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_sample;
    logic               out_valid;
    logic               out_ready;
    logic        [3:0]  out_lag;
    logic signed [31:0] out_r;
    logic               out_sat;

    modport master (
        output in_valid, in_sample, out_ready,
        input  in_ready, out_valid, out_lag, out_r, out_sat
    );

    modport slave (
        input  in_valid, in_sample, out_ready,
        output in_ready, out_valid, out_lag, out_r, out_sat
    );
endinterface

// File: rtl/lpc_autocorr_seq.sv
// Frame buffer plus one shared MAC computing autocorrelation lags R[0..P],
// each delivered saturated to 32 bits over a valid/ready handshake.
module lpc_autocorr_seq #(
    parameter int N  = 64,
    parameter int P  = 10,
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    lpc_autocorr_seq_if.slave io,
    output logic              busy
);
    localparam int CW = AW + 2;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t             state, state_nx;
    logic [AW-1:0]      wr_ptr;
    logic [3:0]         k;
    logic [CW-1:0]      cyc, lim;
    logic signed [15:0] mem [N];
    logic signed [15:0] xa, xb;
    logic signed [31:0] prod;
    logic               v1, v2;
    logic signed [39:0] acc;
    logic [AW-1:0]      rd_a, rd_b;
    logic               accept, issue, done, hshake, last_lag;
    logic               pos_ovf, neg_ovf;

    assign accept   = io.in_valid && io.in_ready;
    assign hshake   = io.out_valid && io.out_ready;
    assign last_lag = (k == 4'(P));
    assign lim      = CW'(N) - CW'(k);
    assign issue    = (state == COMPUTE) && (cyc < lim);
    // read + multiply stages drain two cycles after the last issue
    assign done     = (state == COMPUTE) && (cyc == lim + CW'(1));
    assign rd_b     = cyc[AW-1:0];
    assign rd_a     = cyc[AW-1:0] + AW'(k);
    assign pos_ovf  = !acc[39] && (|acc[38:31]);
    assign neg_ovf  = acc[39] && !(&acc[38:31]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (accept && wr_ptr == AW'(N - 1)) state_nx = COMPUTE;
            COMPUTE: if (done) state_nx = OUTPUT;
            OUTPUT:  if (hshake) state_nx = last_lag ? LOAD : COMPUTE;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        io.in_ready  = (state == LOAD);
        io.out_valid = (state == OUTPUT);
        io.out_lag   = k;
        io.out_r     = '0;
        io.out_sat   = 1'b0;
        busy         = (state != LOAD);
        if (state == OUTPUT) begin
            if (pos_ovf) begin
                io.out_r   = 32'sh7FFF_FFFF;
                io.out_sat = 1'b1;
            end else if (neg_ovf) begin
                io.out_r   = 32'sh8000_0000;
                io.out_sat = 1'b1;
            end else begin
                io.out_r   = acc[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= io.in_sample;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            k      <= '0;
            cyc    <= '0;
            xa     <= '0;
            xb     <= '0;
            prod   <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            acc    <= '0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (issue) begin
                xa <= mem[rd_a];
                xb <= mem[rd_b];
            end
            if (v1) prod <= xa * xb;
            cyc <= (state == COMPUTE && !done) ? cyc + CW'(1) : '0;
            if (state == LOAD || hshake) acc <= '0;
            else if (v2) acc <= acc + $signed({{8{prod[31]}}, prod});
            if (hshake) k <= last_lag ? 4'd0 : k + 4'd1;
        end
    end
endmodule
